alu_muldiv_iter: RTL and testbench

Iterative RV M-extension execution unit, parametrised in `XLEN`, that sits beside the single-cycle ALU/branch lane in the execute stage. It takes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per request and computes it over multiple cycles with a radix-2 shift-add or restoring-division datapath. It returns the result on the standard `rd_sel`/`rd_data` write port. A flush input lets the pipeline abandon an operation when a branch redirects.

---
 rtl/alu_muldiv_iter.sv | 188 ++++++++++++++++++
 tb/tb_alu_muldiv_iter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_iter.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module alu_muldiv_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RGBIT = 5,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  output logic             rdy,
  input  logic [2:0]       funct3,
  input  logic [RGBIT-1:0] rd,
  input  logic [XLEN-1:0]  rs0_word,
  input  logic [XLEN-1:0]  rs1_word,
  input  logic             flush,
  output logic             done,
  output logic [RGBIT-1:0] rd_sel,
  output logic [XLEN-1:0]  rd_data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [RGBIT-1:0]  rd_q, rd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand magnitude for multiplies, divisor magnitude for divides.
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;

  // Request decode, evaluated on the incoming operands.
  logic            is_div, is_rem, a_signed, b_signed, s_a, s_b;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic            div_zero, div_ovf, special, res_neg, accept;

  assign is_div   = funct3[2];
  assign is_rem   = funct3[2] & funct3[1];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
  assign s_a      = a_signed & rs0_word[XLEN-1];
  assign s_b      = b_signed & rs1_word[XLEN-1];
  assign a_mag    = s_a ? (~rs0_word + 1'b1) : rs0_word;
  assign b_mag    = s_b ? (~rs1_word + 1'b1) : rs1_word;
  assign res_neg  = is_rem ? s_a : (s_a ^ s_b);
  assign div_zero = is_div & (rs1_word == '0);
  assign div_ovf  = is_div & ~funct3[0] & (rs0_word == MinNeg) & (rs1_word == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    spec_res = '0;
    if (div_zero) begin
      spec_res = is_rem ? rs0_word : '1;
    end else if (div_ovf) begin
      spec_res = is_rem ? '0 : rs0_word;
    end
  end

  assign rdy    = (state_q == StIdle);
  assign accept = vld & rdy & ~flush;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  // One multiply step: conditional add into the high half, carry kept, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring divide step on {remainder, quotient}.
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ok    = ~div_diff[XLEN];
  assign div_rem   = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc_q[XLEN-2:0], div_ok};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = funct3;
          rd_d   = rd;
          neg_d  = res_neg;
          spec_d = special;
          cnt_d  = CNT_W'(XLEN - 1);
          opb_d  = is_div ? b_mag : a_mag;
          if (special) begin
            acc_d   = {{XLEN{1'b0}}, spec_res};
            state_d = StDone;
          end else if (is_div) begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            state_d = StCalc;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = fast_prod;
            state_d = StDone;
`else
            acc_d   = {{XLEN{1'b0}}, b_mag};
            state_d = StCalc;
`endif
          end
        end
      end
      StCalc: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
    end
  end

  // Sign correction of the finished magnitude result.
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   mul_res, div_val, div_res, result;

  always_comb begin
    prod_c  = neg_q ? (~acc_q + 1'b1) : acc_q;
    mul_res = (op_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    div_val = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_res = neg_q ? (~div_val + 1'b1) : div_val;
    if (spec_q) begin
      result = acc_q[XLEN-1:0];
    end else if (op_q[2]) begin
      result = div_res;
    end else begin
      result = mul_res;
    end
  end

  assign done    = (state_q == StDone) & ~flush;
  assign rd_sel  = done ? rd_q : '0;
  assign rd_data = done ? result : '0;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed bench for alu_muldiv_iter with a cycle-level arithmetic reference model.
module tb_alu_muldiv_iter;

  localparam int XLEN  = 32;
  localparam int RGBIT = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             vld = 1'b0;
  logic             flush = 1'b0;
  logic [2:0]       funct3 = '0;
  logic [RGBIT-1:0] rd = '0;
  logic [XLEN-1:0]  rs0_word = '0;
  logic [XLEN-1:0]  rs1_word = '0;
  logic             rdy;
  logic             done;
  logic [RGBIT-1:0] rd_sel;
  logic [XLEN-1:0]  rd_data;

  alu_muldiv_iter #(.XLEN(XLEN), .RGBIT(RGBIT)) dut (
    .clk(clk), .rst(rst), .vld(vld), .rdy(rdy), .funct3(funct3), .rd(rd),
    .rs0_word(rs0_word), .rs1_word(rs1_word), .flush(flush), .done(done),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Model of the single outstanding operation.
  bit              exp_valid = 1'b0;
  int              acc_e = 0;
  int              exp_cycle = 0;
  logic [4:0]      exp_rd = '0;
  logic [31:0]     exp_data = '0;
  logic [31:0]     exp_lit = '0;
  bit              chk_en = 1'b0;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint    sa, sb, ub, p;
    logic [63:0] pv;
    int        ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; pv = p; return pv[31:0]; end
      3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
      3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
      3'd3: begin pv = {32'h0, a} * {32'h0, b}; return pv[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
    if (!f[2] && FAST) return 0;
    return XLEN;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit busy, exp_done;
      busy     = exp_valid && cyc >= acc_e && cyc <= exp_cycle;
      exp_done = exp_valid && cyc == exp_cycle && !flush;
      check("rdy", {31'h0, rdy}, {31'h0, !busy});
      check("done", {31'h0, done}, {31'h0, exp_done});
      check("rd_sel", {27'h0, rd_sel}, exp_done ? {27'h0, exp_rd} : 32'h0);
      check("rd_data", rd_data, exp_done ? exp_data : 32'h0);
      if (exp_done) check("literal", rd_data, exp_lit);
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (exp_valid && cyc <= exp_cycle) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        n_bad++;
        $display("FAIL idle_wait: model still busy after %0d cycles, required idle", guard);
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit);
    wait_idle();
    funct3   = f;
    rd       = r;
    rs0_word = a;
    rs1_word = b;
    vld      = 1'b1;
    @(posedge clk); #1;
    vld       = 1'b0;
    acc_e     = cyc;
    exp_cycle = cyc + latency(f, a, b);
    exp_rd    = r;
    exp_data  = model(f, a, b);
    exp_lit   = lit;
    exp_valid = 1'b1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;   // reset values checked while rst is still high
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(3'd0, 5'd5,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue(3'd1, 5'd1,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue(3'd3, 5'd2,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue(3'd2, 5'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd3, 5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'd3, 5'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'd0, 5'd0,  32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    issue(3'd1, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(3'd1, 5'd11, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    issue(3'd4, 5'd6,  32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 5'd7,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234);
    issue(3'd5, 5'd12, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    issue(3'd7, 5'd13, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    issue(3'd4, 5'd8,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(3'd6, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(3'd4, 5'd15, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    issue(3'd6, 5'd16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    issue(3'd4, 5'd17, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    issue(3'd6, 5'd18, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(3'd5, 5'd19, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
    issue(3'd7, 5'd20, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002);
    issue(3'd5, 5'd21, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF);
    issue(3'd7, 5'd22, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F);
    issue(3'd5, 5'd23, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(3'd7, 5'd24, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(3'd4, 5'd25, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000);

    // Flush at T+10 of a DIVU, then a new request in T+11.
    issue(3'd5, 5'd26, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
    wait_until(acc_e + 9);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_valid = 1'b0;
    issue(3'd7, 5'd27, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002);

    // Flush in the DONE cycle suppresses the pulse.
    issue(3'd0, 5'd28, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);
    wait_until(exp_cycle);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_valid = 1'b0;

    // vld with flush in IDLE is not accepted.
    funct3 = 3'd5; rd = 5'd29; rs0_word = 32'd9; rs1_word = 32'd3;
    vld = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a divide.
    issue(3'd4, 5'd30, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    wait_until(acc_e + 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_valid = 1'b0;
    @(posedge clk); #1;

    issue(3'd6, 5'd31, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
